strela_main_ctrl: RTL and testbench
===================================

// Module: strela_main_ctrl
// PURPOSE
// Top-level sequencer of the STRELA CGRA, driven by the MMIO control pulses (start/clr/conf_change).
// Decides whether a configuration load is needed, launches the config loader, then the input memory nodes.
// Collects completion from the output memory nodes and raises exec_done/interrupt.
// Its state_o feeds the MMIO performance counters.
// PARAMETERS
// OUTPUT_NODES    4   number of output memory nodes whose completion is collected
// TIMEOUT_CYCLES  0   EXEC watchdog limit in cycles; 0 disables the watchdog
// PORTS
// clk_i          in   1             clock
// rst_i          in   1             synchronous, active-high reset
// start_i        in   1             start pulse from MMIO ctrl.start
// clr_i          in   1             global clear pulse from MMIO ctrl.clr
// conf_change_i  in   1             pulse: stored configuration is stale
// intr_en_i      in   1             interrupt enable (MMIO mode.intr_en)
// conf_done_i    in   1             pulse from config loader: fabric configured
// omn_active_i   in   OUTPUT_NODES  1 = node used in this run (size != 0), sampled at EXEC entry
// omn_done_i     in   OUTPUT_NODES  per-node completion pulse/level
// state_o        out  main_fsm_t    current state
// conf_start_o   out  1             1-cycle pulse: config loader start
// exec_start_o   out  1             1-cycle pulse: memory nodes start
// exec_done_o    out  1             1-cycle pulse: run finished (normal or timeout)
// conf_done_o    out  1             1-cycle pulse: configuration completed
// intr_o         out  1             level interrupt, cleared by start_i or clr_i
// busy_o         out  1             state != S_MAIN_IDLE
// timeout_o      out  1             sticky: last run aborted by watchdog, cleared by start_i/clr_i
// BEHAVIOUR
// - Reset: state S_MAIN_IDLE, all outputs 0, conf_valid=0, done mask=0, watchdog=0, conf_stale=0.
// - FSM states (registered):
//   S_MAIN_IDLE: on start_i, go to S_MAIN_CONF if !conf_valid, else S_MAIN_EXEC.
//   S_MAIN_CONF: single cycle; conf_start_o=1; conf_stale<=0; next S_MAIN_WAIT.
//   S_MAIN_WAIT: waits for conf_done_i. On conf_done_i: conf_done_o=1 in the same cycle;
//     conf_valid<=!(conf_stale|conf_change_i); next S_MAIN_EXEC.
//   S_MAIN_EXEC: in the entry cycle: exec_start_o=1, done mask <= ~omn_active_i,
//     watchdog <= 0. Afterwards: mask |= omn_done_i; watchdog++.
//     Leaves when mask is all-ones or the watchdog hits TIMEOUT_CYCLES (if TIMEOUT_CYCLES != 0).
//     On leaving: exec_done_o=1 for 1 cycle, intr_o<=intr_en_i, timeout_o set on watchdog exit; next S_MAIN_IDLE.
// - A done pulse in the EXEC entry cycle is counted.
// - All omn_active_i=0: finishes 1 cycle after EXEC entry.
// - Latencies:
//   start_i to exec_start_o = 1 cycle with valid config.
//   start_i to conf_start_o = 1 cycle without valid config.
//   Last done to exec_done_o = 1 cycle.
// - Priority: clr_i > rst_i-equivalent state clear > everything else.
//   clr_i in any state gives IDLE next cycle with reset values (incl. conf_valid=0), even mid-WAIT/EXEC.
//   A concurrent start_i is dropped.
// - start_i while busy_o=1: ignored, no queuing.
// - conf_change_i: clears conf_valid immediately. In S_MAIN_CONF/WAIT it sets conf_stale.
//   A configuration loaded during a change is therefore not marked valid.
//   The current run still completes.
// - conf_done_i outside S_MAIN_WAIT: ignored. omn_done_i outside S_MAIN_EXEC: ignored.
// - Watchdog: 32-bit counter, saturating; compare uses >=.
//   TIMEOUT_CYCLES=0 means wait forever.
// TESTING
// - Cold start: rst, start_i, conf_done_i 5 cycles after conf_start_o, omn_active=4'b1111, dones at
//   different cycles -> states IDLE,CONF,WAIT,EXEC,IDLE. Exactly one conf_start_o/exec_start_o/exec_done_o.
// - Warm start: second start_i with no conf_change -> exec_start_o 1 cycle later, no conf_start_o.
//   Then conf_change_i + start_i -> CONF path taken again.
// - Masking: omn_active=4'b0101, only dones 0 and 2 pulse -> exec_done_o 1 cycle after the later one.
//   omn_active=0 -> exec_done_o 1 cycle after exec_start_o.
// - Interrupt: intr_en_i=1 -> intr_o high after run, stays until start_i.
//   intr_en_i=0 -> intr_o stays 0.
// - Watchdog: TIMEOUT_CYCLES=100, one node never done -> exec_done_o 100 cycles after EXEC entry.
//   timeout_o=1, intr_o=1 if enabled.
// - Abort/edge: clr_i mid-WAIT and mid-EXEC -> IDLE next cycle, outputs 0, next start reconfigures.
//   conf_change_i during WAIT -> next start reconfigures.
//   start_i while busy -> no extra pulses.

Source files
------------

// File: rtl/strela_main_ctrl.sv
// STRELA CGRA top-level sequencer: configuration load, execution launch,
// completion collection, watchdog and interrupt generation.
module strela_main_ctrl #(
    parameter int          OUTPUT_NODES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    start_i,
    input  logic                    clr_i,
    input  logic                    conf_change_i,
    input  logic                    intr_en_i,
    input  logic                    conf_done_i,
    input  logic [OUTPUT_NODES-1:0] omn_active_i,
    input  logic [OUTPUT_NODES-1:0] omn_done_i,
    output logic [1:0]              state_o,
    output logic                    conf_start_o,
    output logic                    exec_start_o,
    output logic                    exec_done_o,
    output logic                    conf_done_o,
    output logic                    intr_o,
    output logic                    busy_o,
    output logic                    timeout_o
);

    localparam logic [1:0] S_MAIN_IDLE = 2'd0;
    localparam logic [1:0] S_MAIN_CONF = 2'd1;
    localparam logic [1:0] S_MAIN_WAIT = 2'd2;
    localparam logic [1:0] S_MAIN_EXEC = 2'd3;

    localparam logic [31:0] LP_TIMEOUT = 32'(TIMEOUT_CYCLES);
    localparam logic        LP_WD_EN   = (TIMEOUT_CYCLES != 0);

    logic [1:0]              r_state;
    logic                    r_entry;
    logic                    r_conf_valid;
    logic                    r_conf_stale;
    logic [OUTPUT_NODES-1:0] r_mask;
    logic [31:0]             r_wd;
    logic                    r_intr;
    logic                    r_timeout;

    logic        w_valid_eff;
    logic [31:0] w_wd_inc;
    logic        w_mask_full;
    logic        w_wd_hit;
    logic        w_exec_run;
    logic        w_exit;
    logic        w_conf_ack;
    logic        w_clear;

    assign w_clear     = rst_i | clr_i;
    // A change pulse in the same cycle as start already invalidates the config
    assign w_valid_eff = r_conf_valid & ~conf_change_i;
    assign w_wd_inc    = (r_wd == 32'hFFFF_FFFF) ? r_wd : r_wd + 32'd1;
    assign w_mask_full = &r_mask;
    assign w_wd_hit    = LP_WD_EN && (w_wd_inc >= LP_TIMEOUT);
    assign w_exec_run  = (r_state == S_MAIN_EXEC) && !r_entry;
    assign w_exit      = w_exec_run && (w_mask_full || w_wd_hit);
    assign w_conf_ack  = (r_state == S_MAIN_WAIT) && conf_done_i;

    assign state_o      = r_state;
    assign conf_start_o = (r_state == S_MAIN_CONF) && !clr_i;
    assign exec_start_o = (r_state == S_MAIN_EXEC) && r_entry && !clr_i;
    assign exec_done_o  = w_exit && !clr_i;
    assign conf_done_o  = w_conf_ack && !clr_i;
    assign intr_o       = r_intr;
    assign busy_o       = (r_state != S_MAIN_IDLE);
    assign timeout_o    = r_timeout;

    // Main sequencing FSM with a one-cycle EXEC entry marker
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_state <= S_MAIN_IDLE;
            r_entry <= 1'b0;
        end else begin
            r_entry <= 1'b0;
            unique case (r_state)
                S_MAIN_IDLE: begin
                    if (start_i) begin
                        r_state <= w_valid_eff ? S_MAIN_EXEC : S_MAIN_CONF;
                        r_entry <= w_valid_eff;
                    end
                end
                S_MAIN_CONF: begin
                    r_state <= S_MAIN_WAIT;
                end
                S_MAIN_WAIT: begin
                    if (conf_done_i) begin
                        r_state <= S_MAIN_EXEC;
                        r_entry <= 1'b1;
                    end
                end
                S_MAIN_EXEC: begin
                    if (w_exit) begin
                        r_state <= S_MAIN_IDLE;
                    end
                end
                default: r_state <= S_MAIN_IDLE;
            endcase
        end
    end

    // Configuration validity: a change seen while loading marks the load stale
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_conf_valid <= 1'b0;
            r_conf_stale <= 1'b0;
        end else begin
            if (r_state == S_MAIN_CONF) begin
                r_conf_stale <= conf_change_i;
            end else if ((r_state == S_MAIN_WAIT) && conf_change_i) begin
                r_conf_stale <= 1'b1;
            end
            if (w_conf_ack) begin
                r_conf_valid <= !(r_conf_stale | conf_change_i);
            end else if (conf_change_i) begin
                r_conf_valid <= 1'b0;
            end
        end
    end

    // Completion mask and saturating watchdog during execution
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_mask <= '0;
            r_wd   <= '0;
        end else if (r_state == S_MAIN_EXEC) begin
            if (r_entry) begin
                r_mask <= ~omn_active_i | omn_done_i;
                r_wd   <= '0;
            end else begin
                r_mask <= r_mask | omn_done_i;
                r_wd   <= w_wd_inc;
            end
        end
    end

    // Sticky interrupt and timeout flags, cleared by the next start
    always_ff @(posedge clk_i) begin
        if (w_clear) begin
            r_intr    <= 1'b0;
            r_timeout <= 1'b0;
        end else if (w_exit) begin
            r_intr    <= intr_en_i;
            r_timeout <= w_wd_hit && !w_mask_full;
        end else if (start_i) begin
            r_intr    <= 1'b0;
            r_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_strela_main_ctrl.sv
// Directed self-checking bench for strela_main_ctrl.
// Built with a 100-cycle watchdog and four output nodes.
module tb_strela_main_ctrl;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       start_i = 1'b0;
    logic       clr_i = 1'b0;
    logic       conf_change_i = 1'b0;
    logic       intr_en_i = 1'b0;
    logic       conf_done_i = 1'b0;
    logic [3:0] omn_active_i = 4'h0;
    logic [3:0] omn_done_i = 4'h0;
    logic [1:0] state_o;
    logic       conf_start_o;
    logic       exec_start_o;
    logic       exec_done_o;
    logic       conf_done_o;
    logic       intr_o;
    logic       busy_o;
    logic       timeout_o;

    int n_chk = 0;
    int n_err = 0;
    int n_cs = 0;
    int n_es = 0;
    int n_ed = 0;
    int b_cs, b_es, b_ed;

    strela_main_ctrl #(
        .OUTPUT_NODES  (4),
        .TIMEOUT_CYCLES(100)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .start_i      (start_i),
        .clr_i        (clr_i),
        .conf_change_i(conf_change_i),
        .intr_en_i    (intr_en_i),
        .conf_done_i  (conf_done_i),
        .omn_active_i (omn_active_i),
        .omn_done_i   (omn_done_i),
        .state_o      (state_o),
        .conf_start_o (conf_start_o),
        .exec_start_o (exec_start_o),
        .exec_done_o  (exec_done_o),
        .conf_done_o  (conf_done_o),
        .intr_o       (intr_o),
        .busy_o       (busy_o),
        .timeout_o    (timeout_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (conf_start_o) n_cs = n_cs + 1;
        if (exec_start_o) n_es = n_es + 1;
        if (exec_done_o)  n_ed = n_ed + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
        start_i       = 1'b0;
        clr_i         = 1'b0;
        conf_change_i = 1'b0;
        conf_done_i   = 1'b0;
        omn_done_i    = 4'h0;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic snap();
        b_cs = n_cs;
        b_es = n_es;
        b_ed = n_ed;
    endtask

    initial begin
        // reset
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        smp();
        chk("rst_state", 32'(state_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        chk("rst_intr", 32'(intr_o), 0);
        chk("rst_tmo", 32'(timeout_o), 0);
        chk("rst_pulses", 32'({conf_start_o, exec_start_o,
                                exec_done_o, conf_done_o}), 0);

        // cold start
        omn_active_i = 4'hF;
        nx();
        snap();
        start_i = 1'b1;
        smp();
        chk("cold_idle", 32'(state_o), 0);
        nx();
        smp();
        chk("cold_conf", 32'(state_o), 1);
        chk("cold_cstart", 32'(conf_start_o), 1);
        nx();
        smp();
        chk("cold_wait", 32'(state_o), 2);
        repeat (3) nx();
        nx();
        conf_done_i = 1'b1;
        smp();
        chk("cold_cdone", 32'(conf_done_o), 1);
        nx();
        omn_done_i = 4'b0001;
        smp();
        chk("cold_exec", 32'(state_o), 3);
        chk("cold_estart", 32'(exec_start_o), 1);
        nx();
        omn_done_i = 4'b0010;
        nx();
        nx();
        omn_done_i = 4'b1100;
        smp();
        chk("cold_nodone", 32'(exec_done_o), 0);
        nx();
        smp();
        chk("cold_edone", 32'(exec_done_o), 1);
        nx();
        smp();
        chk("cold_end", 32'(state_o), 0);
        chk("cold_nointr", 32'(intr_o), 0);
        chk("cold_ncs", 32'(n_cs - b_cs), 1);
        chk("cold_nes", 32'(n_es - b_es), 1);
        chk("cold_ned", 32'(n_ed - b_ed), 1);

        // warm start, no active nodes, interrupt enabled
        intr_en_i    = 1'b1;
        omn_active_i = 4'h0;
        nx();
        snap();
        start_i = 1'b1;
        nx();
        smp();
        chk("warm_exec", 32'(state_o), 3);
        chk("warm_estart", 32'(exec_start_o), 1);
        nx();
        smp();
        chk("warm_edone", 32'(exec_done_o), 1);
        nx();
        smp();
        chk("warm_idle", 32'(state_o), 0);
        chk("warm_intr", 32'(intr_o), 1);
        repeat (3) nx();
        smp();
        chk("intr_hold", 32'(intr_o), 1);
        chk("warm_ncs", 32'(n_cs - b_cs), 0);

        // conf_change forces reconfiguration; masked nodes 0 and 2
        nx();
        conf_change_i = 1'b1;
        nx();
        start_i = 1'b1;
        smp();
        chk("intr_pre_clr", 32'(intr_o), 1);
        nx();
        smp();
        chk("chg_conf", 32'(state_o), 1);
        chk("intr_clr", 32'(intr_o), 0);
        omn_active_i = 4'b0101;
        nx();
        nx();
        conf_done_i = 1'b1;
        nx();
        smp();
        chk("mask_entry", 32'(state_o), 3);
        nx();
        omn_done_i = 4'b0001;
        nx();
        nx();
        omn_done_i = 4'b0100;
        smp();
        chk("mask_nodone", 32'(exec_done_o), 0);
        nx();
        smp();
        chk("mask_edone", 32'(exec_done_o), 1);
        nx();
        smp();
        chk("mask_intr", 32'(intr_o), 1);

        // watchdog: node 1 never completes
        omn_active_i = 4'b0011;
        nx();
        snap();
        start_i = 1'b1;
        nx();
        smp();
        chk("wd_entry", 32'(exec_start_o), 1);
        chk("wd_intr_clr", 32'(intr_o), 0);
        nx();
        omn_done_i = 4'b0001;
        repeat (98) nx();
        smp();
        chk("wd_early", 32'(exec_done_o), 0);
        chk("wd_ned0", 32'(n_ed - b_ed), 0);
        nx();
        smp();
        chk("wd_fire", 32'(exec_done_o), 1);
        nx();
        smp();
        chk("wd_tmo", 32'(timeout_o), 1);
        chk("wd_intr", 32'(intr_o), 1);
        chk("wd_idle", 32'(state_o), 0);

        // clear mid-EXEC
        nx();
        start_i = 1'b1;
        nx();
        smp();
        chk("clr_x_exec", 32'(state_o), 3);
        chk("tmo_clr", 32'(timeout_o), 0);
        nx();
        clr_i = 1'b1;
        nx();
        smp();
        chk("clr_x_idle", 32'(state_o), 0);
        chk("clr_x_busy", 32'(busy_o), 0);
        chk("clr_x_edone", 32'(exec_done_o), 0);
        nx();
        start_i = 1'b1;
        nx();
        smp();
        chk("clr_reconf", 32'(state_o), 1);

        // clear mid-WAIT
        nx();
        smp();
        chk("clr_w_wait", 32'(state_o), 2);
        nx();
        clr_i = 1'b1;
        nx();
        smp();
        chk("clr_w_idle", 32'(state_o), 0);
        nx();
        start_i = 1'b1;
        nx();
        smp();
        chk("clr_w_reconf", 32'(state_o), 1);

        // conf_change during WAIT plus start while busy
        omn_active_i = 4'h0;
        nx();
        snap();
        conf_change_i = 1'b1;
        start_i = 1'b1;
        nx();
        conf_done_i = 1'b1;
        smp();
        chk("stale_cdone", 32'(conf_done_o), 1);
        nx();
        start_i = 1'b1;
        smp();
        chk("stale_exec", 32'(state_o), 3);
        nx();
        smp();
        chk("stale_edone", 32'(exec_done_o), 1);
        nx();
        smp();
        chk("stale_idle", 32'(state_o), 0);
        chk("busy_ncs", 32'(n_cs - b_cs), 0);
        chk("busy_nes", 32'(n_es - b_es), 1);
        chk("busy_ned", 32'(n_ed - b_ed), 1);
        nx();
        start_i = 1'b1;
        nx();
        smp();
        chk("stale_reconf", 32'(state_o), 1);
        nx();
        clr_i = 1'b1;
        nx();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
